// File: rtl/uart_pkg.sv
// Shared definitions for the 20-bit capstone serial link (transmitter side).
// Holds the frame geometry, the line-level start/stop values, the transmitter
// state encoding, the receiver's error code and a frame-building helper.
package uart_pkg;

  localparam int unsigned MSG_W      = 20;
  localparam int unsigned FRAME_BITS = 22;
  localparam int unsigned IDX_W      = 5;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  // Error code reported by the paired receiver path.
  localparam logic [4:0] RX_ERR_CODE = 5'h15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Wire order from MSB down: start, message MSB-first, stop.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [MSG_W-1:0] msg);
    return {START_BIT, msg, STOP_BIT};
  endfunction

endpackage

// File: rtl/uart_transmitter_piso.sv
// Parallel-in serial-out shift register, the transmit counterpart of the
// receiver's SIPO register. Shifts left, so the MSB leaves the block first.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset (clears to 0)
//   load         : capture data (has priority over en)
//   en           : shift one position toward the MSB, filling with 0
//   data         : parallel load value
//   out          : current MSB (a flop output, so it is registered)
module uart_transmitter_piso #(
  parameter int unsigned WIDTH = 22
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic             out
);

  logic [WIDTH-1:0] shreg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= data;
    end else if (en) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign out = shreg[WIDTH-1];

endmodule

// File: rtl/uart_transmitter.sv
// Parallel-to-serial transmitter for the 20-bit serial link. A message taken
// on send && ready goes out as a 22-bit frame (start 1, data MSB-first,
// stop 0) on an idle-low line, each bit held CLKS_PER_BIT clocks.
// Optional feature macro: UART_TX_BUFFER_EN adds a one-entry holding
// register so a second message can be accepted while a frame is in flight.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   send         : transmit request
//   message      : 20-bit payload, sampled only on acceptance
//   ready        : a message can be accepted this cycle
//   serialOut    : registered serial line, idle 0
//   busy         : frame in progress (START through STOP)
//   done         : one-cycle pulse on the last clock of the stop bit
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             send,
  input  logic [MSG_W-1:0] message,
  output logic             ready,
  output logic             serialOut,
  output logic             busy,
  output logic             done
);

  localparam int unsigned TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TIMER_W-1:0] LAST_TICK     = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] DONE_TICK     = TIMER_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0]   LAST_DATA_IDX = IDX_W'(MSG_W);

  tx_state_t          state;
  logic [TIMER_W-1:0] bit_timer;
  logic [IDX_W-1:0]   bit_idx;

  logic             accept;
  logic             bit_end;
  logic             last_bit_end;
  logic             next_valid;
  logic             load;
  logic             shift_en;
  logic [MSG_W-1:0] load_msg;

  assign accept       = send & ready;
  assign bit_end      = (bit_timer == LAST_TICK);
  assign last_bit_end = (state == STOP) && bit_end;

`ifdef UART_TX_BUFFER_EN
  logic             full;
  logic [MSG_W-1:0] hold;
  logic             store;

  // A held message always wins the stop-bit slot; ready is low while full,
  // so accept cannot coincide with it.
  assign load_msg   = full ? hold : message;
  assign next_valid = full | accept;
  assign store      = accept & ~load;
`else
  assign load_msg   = message;
  assign next_valid = accept;
`endif

  // Load from IDLE, or chain the next frame straight after the stop bit.
  assign load     = ((state == IDLE) && accept) || (last_bit_end && next_valid);
  assign shift_en = bit_end && ((state == START) || (state == DATA));

  assign busy = (state != IDLE);

  // Frame sequencer: state, bit timer, bit index and handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_timer <= '0;
      bit_idx   <= '0;
      ready     <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      if (state != IDLE) begin
        bit_timer <= bit_end ? '0 : TIMER_W'(bit_timer + 1'b1);
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state     <= START;
            bit_timer <= '0;
            bit_idx   <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= IDX_W'(bit_idx + 1'b1);
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_idx <= IDX_W'(bit_idx + 1'b1);
            if (bit_idx == LAST_DATA_IDX) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          // Registered, so it is raised one tick early to land on the last clock.
          if (bit_timer == DONE_TICK) begin
            done <= 1'b1;
          end
          if (bit_end) begin
            bit_idx <= '0;
            state   <= next_valid ? START : IDLE;
          end
        end
        default: state <= IDLE;
      endcase

`ifdef UART_TX_BUFFER_EN
      if (store) begin
        ready <= 1'b0;
      end else if (last_bit_end) begin
        ready <= 1'b1;
      end
`else
      if (load) begin
        ready <= 1'b0;
      end else if ((state == STOP) && (bit_timer == DONE_TICK)) begin
        ready <= 1'b1;
      end
`endif
    end
  end

`ifdef UART_TX_BUFFER_EN
  // One-entry holding register; its full flag is what ready reflects.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      hold <= '0;
    end else if (store) begin
      full <= 1'b1;
      hold <= message;
    end else if (last_bit_end) begin
      full <= 1'b0;
    end
  end
`endif

  uart_transmitter_piso #(
    .WIDTH(FRAME_BITS)
  ) u_piso (
    .clock(clock),
    .reset(reset),
    .load (load),
    .en   (shift_en),
    .data (make_frame(load_msg)),
    .out  (serialOut)
  );

endmodule
